// File: rtl/seg_scan_decoder.sv
// Capture side of a multiplexed 7-segment scan: rebuilds the 8-digit frame from
// scan index + active-low segments, decodes each digit to hex and flags frame events.
module seg_scan_decoder #(
    parameter int SETTLE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  scanin,
    input  logic [7:0]  segin,
    output logic [55:0] digit_seg,
    output logic [7:0]  dp_n,
    output logic [31:0] digit_hex,
    output logic [7:0]  digit_valid,
    output logic        frame_done,
    output logic        frame_changed,
    output logic        scan_err
);
    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(SETTLE);
    localparam logic [CW-1:0] CNT_SAMPLE = CW'(SETTLE - 2);

    localparam logic [0:0] HUNT    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    logic [2:0]    scan_m, idx_s, prev_idx, next_idx;
    logic [7:0]    seg_m, seg_s;
    logic [CW-1:0] cnt;
    logic [0:0]    state;
    logic [7:0]    seen;
    logic [55:0]   shadow, shadow_next;
    logic [7:0]    shadow_dp, shadow_dp_next;
    logic          idx_change, sample, seq_bad, store, commit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_m <= '0;
            idx_s  <= '0;
            seg_m  <= '0;
            seg_s  <= '0;
        end else begin
            scan_m <= scanin;
            idx_s  <= scan_m;
            seg_m  <= segin;
            seg_s  <= seg_m;
        end
    end

    // The counter's next value reaching SETTLE-1 marks the single sample point of a dwell.
    always_comb begin
        next_idx       = prev_idx + 3'd1;
        idx_change     = (idx_s != prev_idx);
        sample         = !idx_change && (cnt == CNT_SAMPLE);
        seq_bad        = (state == COLLECT) && idx_change && (idx_s != next_idx);
        store          = sample && !seq_bad && ((state == COLLECT) || (idx_s == 3'd0));
        commit         = store && (state == COLLECT) && (idx_s == 3'd7) &&
                         ((seen | 8'h80) == 8'hFF);
        shadow_next    = shadow;
        shadow_dp_next = shadow_dp;
        if (store) begin
            shadow_next[int'(idx_s) * 7 +: 7] = seg_s[6:0];
            shadow_dp_next[idx_s]             = seg_s[7];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_idx      <= '0;
            cnt           <= '0;
            state         <= HUNT;
            seen          <= '0;
            shadow        <= '1;
            shadow_dp     <= '1;
            digit_seg     <= '1;
            dp_n          <= '1;
            frame_done    <= 1'b0;
            frame_changed <= 1'b0;
            scan_err      <= 1'b0;
        end else begin
            prev_idx  <= idx_s;
            shadow    <= shadow_next;
            shadow_dp <= shadow_dp_next;
            scan_err  <= seq_bad;

            if (idx_change)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;

            if (seq_bad) begin
                // Saturating the counter discards the offending dwell, even at index 0.
                state <= HUNT;
                seen  <= '0;
                cnt   <= CNT_MAX;
            end else if (store) begin
                if (state == HUNT) begin
                    state <= COLLECT;
                    seen  <= 8'h01;
                end else if (idx_s == 3'd7) begin
                    seen <= '0;
                end else begin
                    seen[idx_s] <= 1'b1;
                end
            end

            frame_done    <= commit;
            frame_changed <= commit && ({shadow_next, shadow_dp_next} != {digit_seg, dp_n});
            if (commit) begin
                digit_seg <= shadow_next;
                dp_n      <= shadow_dp_next;
            end
        end
    end

    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b1000000: decode = 5'h10;
            7'b1111001: decode = 5'h11;
            7'b0100100: decode = 5'h12;
            7'b0110000: decode = 5'h13;
            7'b0011001: decode = 5'h14;
            7'b0010010: decode = 5'h15;
            7'b0000010: decode = 5'h16;
            7'b1111000: decode = 5'h17;
            7'b0000000: decode = 5'h18;
            7'b0010000: decode = 5'h19;
            7'b0001000: decode = 5'h1A;
            7'b0000011: decode = 5'h1B;
            7'b1000110: decode = 5'h1C;
            7'b0100001: decode = 5'h1D;
            7'b0000110: decode = 5'h1E;
            7'b0001110: decode = 5'h1F;
            default:    decode = 5'h00;
        endcase
    endfunction

    always_comb begin
        digit_hex   = '0;
        digit_valid = '0;
        for (int k = 0; k < 8; k++)
            {digit_valid[k], digit_hex[4*k +: 4]} = decode(digit_seg[7*k +: 7]);
    end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: dwell-level reference model predicts commit/error
// pulses and the displayed frame; a negedge process compares every cycle.
module tb_seg_scan_decoder;
  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  scanin;
  logic [7:0]  segin;
  logic [55:0] digit_seg;
  logic [7:0]  dp_n;
  logic [31:0] digit_hex;
  logic [7:0]  digit_valid;
  logic        frame_done;
  logic        frame_changed;
  logic        scan_err;

  seg_scan_decoder #(.SETTLE(SETTLE)) dut (
    .clk(clk),
    .reset(reset),
    .scanin(scanin),
    .segin(segin),
    .digit_seg(digit_seg),
    .dp_n(dp_n),
    .digit_hex(digit_hex),
    .digit_valid(digit_valid),
    .frame_done(frame_done),
    .frame_changed(frame_changed),
    .scan_err(scan_err)
  );

  always #5 clk = ~clk;

  // Edge counter: value k while the outputs produced by edge k are visible.
  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  logic [6:0] hex_pat [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  typedef struct {
    int          cyc;
    logic        changed;
    logic [55:0] seg;
    logic [7:0]  dp;
  } done_t;

  done_t done_q[$];
  int    err_q[$];

  int vectors = 0;
  int miscompares = 0;
  int n_done = 0, n_changed = 0, n_err = 0;

  logic        m_hunt;
  logic [7:0]  m_seen;
  logic [2:0]  m_prev;
  logic [7:0]  m_shadow [8];
  logic [55:0] m_seg, exp_seg;
  logic [7:0]  m_dp, exp_dp;
  logic [7:0]  rnd_frame [8];
  logic        e_done, e_chg, e_err;
  logic [39:0] dec;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [39:0] decode_frame(input logic [55:0] s);
    logic [7:0]  v = '0;
    logic [31:0] h = '0;
    for (int k = 0; k < 8; k++)
      for (int d = 0; d < 16; d++)
        if (s[7*k +: 7] == hex_pat[d]) begin
          v[k] = 1'b1;
          h[4*k +: 4] = 4'(d);
        end
    return {v, h};
  endfunction

  // One dwell of index v (inputs applied right after edge n, held len cycles).
  task automatic model_dwell(input logic [2:0] v, input logic [7:0] p, input int len, input int n);
    done_t       d;
    if (!m_hunt && int'(v) != (int'(m_prev) + 1) % 8) begin
      err_q.push_back(n + 3);
      m_hunt = 1'b1;
      m_seen = '0;
    end else if (len >= SETTLE) begin
      if (m_hunt) begin
        if (v == 3'd0) begin
          m_hunt = 1'b0;
          m_seen = 8'h01;
          m_shadow[0] = p;
        end
      end else begin
        m_shadow[v] = p;
        m_seen[v] = 1'b1;
        if (v == 3'd7) begin
          if (m_seen == 8'hFF) begin
            for (int k = 0; k < 8; k++) begin
              d.seg[7*k +: 7] = m_shadow[k][6:0];
              d.dp[k] = m_shadow[k][7];
            end
            d.cyc = n + 2 + SETTLE;
            d.changed = ({d.seg, d.dp} != {m_seg, m_dp});
            done_q.push_back(d);
            m_seg = d.seg;
            m_dp = d.dp;
          end
          m_seen = '0;
        end
      end
    end
    m_prev = v;
  endtask

  task automatic dwell(input logic [2:0] v, input logic [7:0] p, input int len);
    scanin = v;
    segin = p;
    model_dwell(v, p, len, cyc);
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [2:0] first_idx);
    reset = 1'b1;
    scanin = first_idx;
    segin = 8'hFF;
    done_q.delete();
    err_q.delete();
    m_hunt = 1'b1;
    m_seen = '0;
    m_prev = '0;
    m_seg = '1;
    m_dp = '1;
    exp_seg = '1;
    exp_dp = '1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_seg"}, digit_seg, {56{1'b1}});
    check({tag, "_dp"}, dp_n, 8'hFF);
    check({tag, "_hex"}, digit_hex, 32'h0);
    check({tag, "_valid"}, digit_valid, 8'h00);
    check({tag, "_pulses"}, {frame_done, frame_changed, scan_err}, 3'b000);
  endtask

  task automatic new_frame();
    for (int k = 0; k < 8; k++)
      rnd_frame[k] = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                     : {1'($urandom), hex_pat[$urandom_range(0, 15)]};
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      e_done = 1'b0;
      e_chg = 1'b0;
      e_err = 1'b0;
      if (err_q.size() > 0 && err_q[0] == cyc) begin
        e_err = 1'b1;
        void'(err_q.pop_front());
      end
      if (done_q.size() > 0 && done_q[0].cyc == cyc) begin
        e_done = 1'b1;
        e_chg = done_q[0].changed;
        exp_seg = done_q[0].seg;
        exp_dp = done_q[0].dp;
        void'(done_q.pop_front());
      end
      dec = decode_frame(exp_seg);
      check("frame_done", frame_done, e_done);
      check("frame_changed", frame_changed, e_chg);
      check("scan_err", scan_err, e_err);
      check("digit_seg", digit_seg, exp_seg);
      check("dp_n", dp_n, exp_dp);
      check("digit_hex", digit_hex, dec[31:0]);
      check("digit_valid", digit_valid, dec[39:32]);
      if (frame_done) n_done++;
      if (frame_changed) n_changed++;
      if (scan_err) n_err++;
    end
  end

  initial begin
    int d0, c0, r0;
    logic [2:0] v, prev_v;
    scanin = 3'd0;
    segin = 8'hFF;

    // Reset values, then a clean "01234567" scan twice
    do_reset(3'd7);
    check_reset_values("reset");
    dwell(3'd7, 8'hFF, 10);
    d0 = n_done; c0 = n_changed;
    for (int d = 0; d < 8; d++) dwell(3'(d), {1'b1, hex_pat[d]}, 64);
    check("clean_hex", digit_hex, 32'h76543210);
    check("clean_valid", digit_valid, 8'hFF);
    check("clean_done1", n_done - d0, 1);
    check("clean_chg1", n_changed - c0, 1);
    for (int d = 0; d < 8; d++) dwell(3'(d), {1'b1, hex_pat[d]}, 64);
    check("clean_done2", n_done - d0, 2);
    check("clean_chg2", n_changed - c0, 1);

    // Blank digits with a dash on digit 7
    for (int d = 0; d < 7; d++) dwell(3'(d), 8'hFF, 8);
    dwell(3'd7, 8'hBF, 8);
    check("dash_seg7", digit_seg[55:49], 7'b0111111);
    check("dash_valid", digit_valid, 8'h00);
    check("dash_hex", digit_hex, 32'h0);

    // Out-of-order 0,1,2,4..7, then a full sweep
    d0 = n_done; r0 = n_err;
    foreach (hex_pat[i]) if (i < 8 && i != 3) dwell(3'(i), {1'b1, hex_pat[i + 8]}, 8);
    check("ooo_err", n_err - r0, 1);
    check("ooo_nodone", n_done - d0, 0);
    for (int d = 0; d < 8; d++) dwell(3'(d), {1'b1, hex_pat[d + 8]}, 8);
    check("ooo_done", n_done - d0, 1);
    check("ooo_hex", digit_hex, 32'hFEDCBA98);

    // Glitched dwell on idx 5
    d0 = n_done; r0 = n_err;
    for (int d = 0; d < 8; d++) dwell(3'(d), {1'b0, hex_pat[d]}, (d == 5) ? 2 : 8);
    check("glitch_nodone", n_done - d0, 0);
    check("glitch_noerr", n_err - r0, 0);
    for (int d = 0; d < 8; d++) dwell(3'(d), {1'b0, hex_pat[d]}, 8);
    check("glitch_done", n_done - d0, 1);
    check("glitch_dp", dp_n, 8'h00);

    // Start mid-sweep after reset
    do_reset(3'd3);
    d0 = n_done;
    for (int d = 3; d < 8; d++) dwell(3'(d), {1'b1, hex_pat[d]}, 8);
    check("mid_nodone", n_done - d0, 0);
    for (int d = 0; d < 8; d++) dwell(3'(d), {1'b1, hex_pat[7 - d]}, 8);
    check("mid_done", n_done - d0, 1);
    check("mid_hex", digit_hex, 32'h01234567);

    // Async reset during idx 6
    for (int d = 0; d < 6; d++) dwell(3'(d), {1'b1, hex_pat[d]}, 8);
    dwell(3'd6, {1'b1, hex_pat[6]}, 10);
    #2 reset = 1'b1;
    #1 check_reset_values("async");
    do_reset(3'd1);
    d0 = n_done;
    for (int d = 1; d < 8; d++) dwell(3'(d), {1'b1, hex_pat[d]}, 8);
    check("post_rst_nodone", n_done - d0, 0);
    for (int d = 0; d < 8; d++) dwell(3'(d), {1'b1, hex_pat[d]}, 8);
    check("post_rst_done", n_done - d0, 1);

    // Randomized scanning with occasional glitches and skips
    new_frame();
    prev_v = 3'd7;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) v = 3'($urandom_range(0, 7));
      else v = prev_v + 3'd1;
      if (v == prev_v) v = v + 3'd2;
      if (v == 3'd0 && $urandom_range(0, 2) == 0) new_frame();
      dwell(v, rnd_frame[v],
            ($urandom_range(0, 9) == 0) ? $urandom_range(1, SETTLE - 1)
                                         : $urandom_range(SETTLE, SETTLE + 8));
      prev_v = v;
    end
    repeat (4) @(posedge clk);
    #1;
    check("queues_drained", done_q.size() + err_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
